// File: rtl/scan_test_controller_if.sv
// Vector stream from the pattern source (ROM, FIFO or bench) into the scan test controller.
// XMASK_EN adds per-bit don't-care masks for captured state and primary outputs.
interface scan_test_controller_if #(
   parameter int NUM_CHAINS = 2,
   parameter int CHAIN_LEN  = 13,
   parameter int PI_W       = 8,
   parameter int PO_W       = 8
);
   logic                            vec_valid;
   logic                            vec_ready;
   logic                            vec_last;
   logic [PI_W-1:0]                 vec_pi;
   logic [NUM_CHAINS*CHAIN_LEN-1:0] vec_scan;
   logic [NUM_CHAINS*CHAIN_LEN-1:0] vec_exp_st;
   logic [PO_W-1:0]                 vec_exp_po;
`ifdef XMASK_EN
   logic [NUM_CHAINS*CHAIN_LEN-1:0] vec_mask_st;
   logic [PO_W-1:0]                 vec_mask_po;
`endif

   modport master (
      output vec_valid, vec_last, vec_pi, vec_scan, vec_exp_st, vec_exp_po,
`ifdef XMASK_EN
      output vec_mask_st, vec_mask_po,
`endif
      input  vec_ready
   );

   modport slave (
      input  vec_valid, vec_last, vec_pi, vec_scan, vec_exp_st, vec_exp_po,
`ifdef XMASK_EN
      input  vec_mask_st, vec_mask_po,
`endif
      output vec_ready
   );
endinterface

// File: rtl/scan_test_controller.sv
// Full-scan sequencer: per vector CHAIN_LEN shift cycles + capture + compare (CHAIN_LEN+3 cycles incl. LOAD);
// vec_ready only in LOAD, chains hold while the source stalls. XMASK_EN enables don't-care masking.
module scan_test_controller #(
   parameter int NUM_CHAINS = 2,
   parameter int CHAIN_LEN  = 13,
   parameter int PI_W       = 8,
   parameter int PO_W       = 8,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  global_reset,
   input  logic                  start,
   input  logic                  stop_on_fail,
   scan_test_controller_if.slave vec,
   output logic                  NbarT,
   output logic [NUM_CHAINS-1:0] si,
   input  logic [NUM_CHAINS-1:0] so,
   output logic [PI_W-1:0]       dut_pi,
   input  logic [PO_W-1:0]       dut_po,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [CNT_W-1:0]      vec_count,
   output logic [CNT_W-1:0]      fail_count,
   output logic [CNT_W-1:0]      first_fail_idx
);
   localparam int SW = NUM_CHAINS * CHAIN_LEN;
   localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

   typedef enum logic [2:0] {
      IDLE, LOAD, SHIFT, CAPTURE, COMPARE, UNLOAD, UCOMPARE, DONE
   } state_t;

   state_t          state, state_nx;
   logic [SW-1:0]   scan_sh, unload, pend_st, cmp_st, st_care, ust_care;
   logic [PI_W-1:0] pi_r;
   logic [PO_W-1:0] exp_po_r, po_r, po_care;
   logic [CW-1:0]   sh_cnt;
   logic            last_r, stop_r, first_vec;
   logic            sh_last, po_mis, st_mis, ust_mis, mis, rdy;

`ifdef XMASK_EN
   logic [SW-1:0]   pend_mask, cmp_mask;
   logic [PO_W-1:0] mask_po_r;
   assign st_care  = ~cmp_mask;
   assign ust_care = ~pend_mask;
   assign po_care  = ~mask_po_r;
`else
   assign st_care  = '1;
   assign ust_care = '1;
   assign po_care  = '1;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The unload during vector N's shift is vector N-1's capture, hence cmp_st lags pend_st by one vector.
   assign sh_last = (sh_cnt == CW'(CHAIN_LEN - 1));
   assign po_mis  = |((po_r ^ exp_po_r) & po_care);
   assign st_mis  = ~first_vec & (|((unload ^ cmp_st) & st_care));
   assign ust_mis = |((unload ^ pend_st) & ust_care);
   assign mis     = (state == UCOMPARE) ? ust_mis : (po_mis | st_mis);
   assign vec.vec_ready = rdy;

   always_comb begin
      state_nx = state;
      rdy      = 1'b0;
      NbarT    = 1'b0;
      si       = '0;
      dut_pi   = '0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = LOAD;
         end
         LOAD: begin
            rdy = 1'b1;
            if (vec.vec_valid) state_nx = SHIFT;
         end
         SHIFT: begin
            NbarT = 1'b1;
            for (int c = 0; c < NUM_CHAINS; c++) si[c] = scan_sh[c*CHAIN_LEN];
            if (sh_last) state_nx = CAPTURE;
         end
         CAPTURE: begin
            dut_pi   = pi_r;
            state_nx = COMPARE;
         end
         COMPARE: begin
            if (stop_r && mis) state_nx = DONE;
            else if (last_r)   state_nx = UNLOAD;
            else               state_nx = LOAD;
         end
         UNLOAD: begin
            NbarT = 1'b1;
            if (sh_last) state_nx = UCOMPARE;
         end
         UCOMPARE: state_nx = DONE;
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_nx = LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge global_reset) begin
      if (!global_reset) begin
         state          <= IDLE;
         scan_sh        <= '0;
         unload         <= '0;
         pend_st        <= '0;
         cmp_st         <= '0;
         pi_r           <= '0;
         exp_po_r       <= '0;
         po_r           <= '0;
         sh_cnt         <= '0;
         last_r         <= 1'b0;
         stop_r         <= 1'b0;
         first_vec      <= 1'b1;
         fail           <= 1'b0;
         vec_count      <= '0;
         fail_count     <= '0;
         first_fail_idx <= '1;
`ifdef XMASK_EN
         pend_mask      <= '0;
         cmp_mask       <= '0;
         mask_po_r      <= '0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            IDLE, DONE: if (start) begin
               vec_count      <= '0;
               fail_count     <= '0;
               first_fail_idx <= '1;
               fail           <= 1'b0;
               first_vec      <= 1'b1;
               stop_r         <= stop_on_fail;
            end
            LOAD: if (vec.vec_valid) begin
               scan_sh  <= vec.vec_scan;
               pi_r     <= vec.vec_pi;
               exp_po_r <= vec.vec_exp_po;
               last_r   <= vec.vec_last;
               cmp_st   <= pend_st;
               pend_st  <= vec.vec_exp_st;
               sh_cnt   <= '0;
`ifdef XMASK_EN
               cmp_mask  <= pend_mask;
               pend_mask <= vec.vec_mask_st;
               mask_po_r <= vec.vec_mask_po;
`endif
            end
            SHIFT, UNLOAD: begin
               sh_cnt <= sh_cnt + 1'b1;
               for (int c = 0; c < NUM_CHAINS; c++) begin
                  scan_sh[c*CHAIN_LEN +: CHAIN_LEN] <= {1'b0, scan_sh[c*CHAIN_LEN+1 +: CHAIN_LEN-1]};
                  unload[c*CHAIN_LEN +: CHAIN_LEN]  <= {so[c], unload[c*CHAIN_LEN+1 +: CHAIN_LEN-1]};
               end
            end
            CAPTURE: po_r <= dut_po;
            COMPARE: begin
               vec_count <= sat_inc(vec_count);
               first_vec <= 1'b0;
               sh_cnt    <= '0;
               if (mis) begin
                  fail       <= 1'b1;
                  fail_count <= sat_inc(fail_count);
                  if (!fail) first_fail_idx <= vec_count;
               end
            end
            UCOMPARE: if (mis) begin
               fail       <= 1'b1;
               fail_count <= sat_inc(fail_count);
               if (!fail) first_fail_idx <= vec_count - 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: a scanned-core model on si/so, a vector-level pass/fail model,
// and a negedge monitor checking shift data, shift length and per-vector counters.
module tb_scan_test_controller;
   localparam int NC = 2, L = 13, SW = NC * L, PIW = 8, POW = 8, CW = 16;

   logic            clk = 1'b0;
   logic            global_reset, start, stop_on_fail;
   logic            NbarT, busy, done, fail;
   logic [NC-1:0]   si, so;
   logic [PIW-1:0]  dut_pi;
   logic [POW-1:0]  dut_po;
   logic [CW-1:0]   vec_count, fail_count, first_fail_idx;

   scan_test_controller_if #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .PI_W(PIW), .PO_W(POW)) vif ();

   scan_test_controller #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .PI_W(PIW), .PO_W(POW), .CNT_W(CW)) dut (
      .clk(clk), .global_reset(global_reset), .start(start), .stop_on_fail(stop_on_fail),
      .vec(vif), .NbarT(NbarT), .si(si), .so(so), .dut_pi(dut_pi), .dut_po(dut_po),
      .busy(busy), .done(done), .fail(fail), .vec_count(vec_count),
      .fail_count(fail_count), .first_fail_idx(first_fail_idx)
   );

   always #5 clk = ~clk;

   // Core function in scan layout: captured state and primary outputs.
   function automatic logic [SW-1:0] cap_f(input logic [SW-1:0] s, input logic [7:0] p);
      return {s[SW-2:0], s[SW-1]} ^ {p[1:0], p, p, p};
   endfunction
   function automatic logic [7:0] po_f(input logic [SW-1:0] s, input logic [7:0] p);
      return s[7:0] + p;
   endfunction

   // Scanned core: shifts while NbarT, captures on the first functional clock after a shift.
   logic [SW-1:0] core = '0;
   logic          nb_q = 1'b0;
   logic          stuck1 = 1'b0;
   always @(posedge clk) begin
      nb_q <= NbarT;
      if (NbarT) begin
         for (int c = 0; c < NC; c++) core[c*L +: L] <= {si[c], core[c*L+1 +: L-1]};
      end else if (nb_q) begin
         core <= cap_f(core, dut_pi);
      end
   end
   assign so     = {core[L] | stuck1, core[0]};
   assign dut_po = po_f(core, dut_pi);

   logic [SW-1:0] tbl_scan [4] = '{26'h1234567, 26'h3FFFFFF, 26'h0000001, 26'h2A5A5A5};
   logic [7:0]    tbl_pi   [4] = '{8'h00, 8'hFF, 8'h3C, 8'h81};

   logic [SW-1:0] v_scan [8], v_exp_st [8], v_mst [8];
   logic [7:0]    v_pi [8], v_exp_po [8], v_mpo [8];
   int            n_vec;
   int            m_pre_fail [8];
   int            m_count, m_fails, m_first, m_runs;
   int            total = 0, bad = 0;
   int            hs, runs, run_len;
   bit            mon_clr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic load_vecs(input int n, input bit zero_exp);
      for (int i = 0; i < n; i++) begin
         v_scan[i]   = tbl_scan[i];
         v_pi[i]     = tbl_pi[i];
         v_exp_st[i] = zero_exp ? '0 : cap_f(tbl_scan[i], tbl_pi[i]);
         v_exp_po[i] = po_f(tbl_scan[i], tbl_pi[i]);
         v_mst[i]    = '0;
         v_mpo[i]    = '0;
      end
   endtask

   // Vector-level outcome: vector i compares its PO and the capture of vector i-1.
   task automatic build_model(input int n, input bit stp, input bit stk);
      logic [SW-1:0] obs [8];
      logic [SW-1:0] cap;
      bit            mis;
      m_fails = 0; m_first = -1; m_count = 0; m_runs = 0;
      for (int i = 0; i < n; i++) begin
         m_pre_fail[i] = m_fails;
         cap    = cap_f(v_scan[i], v_pi[i]);
         obs[i] = stk ? (cap | {{L{1'b1}}, {L{1'b0}}}) : cap;
         mis    = (((po_f(v_scan[i], v_pi[i]) ^ v_exp_po[i]) & ~v_mpo[i]) != 0);
         if (i > 0 && (((obs[i-1] ^ v_exp_st[i-1]) & ~v_mst[i-1]) != 0)) mis = 1'b1;
         if (mis) begin m_fails++; if (m_first < 0) m_first = m_count; end
         m_count++;
         m_runs++;
         if (stp && mis) break;
         if (i == n - 1) begin
            m_runs++;
            if (((obs[i] ^ v_exp_st[i]) & ~v_mst[i]) != 0) begin
               m_fails++;
               if (m_first < 0) m_first = m_count - 1;
            end
         end
      end
   endtask

   task automatic monitor();
      logic [NC-1:0] esi;
      forever begin
         @(negedge clk);
         if (!global_reset || mon_clr) begin
            hs = 0; runs = 0; run_len = 0;
         end else begin
            if (vif.vec_valid && vif.vec_ready && hs < 8) begin
               chk("hs_vec_count", vec_count, hs);
               chk("hs_fail_count", fail_count, m_pre_fail[hs]);
               hs++;
            end
            if (NbarT) begin
               esi = '0;
               if (runs < hs && run_len < L)
                  for (int c = 0; c < NC; c++) esi[c] = v_scan[runs][c*L + run_len];
               chk("si", si, esi);
               run_len++;
            end else if (run_len != 0) begin
               chk("nbart_len", run_len, L);
               runs++;
               run_len = 0;
            end
         end
      end
   endtask

   task automatic feed_vec(input int i, output bit ok);
      ok = 1'b0;
      vif.vec_valid  = 1'b1;
      vif.vec_last   = (i == n_vec - 1);
      vif.vec_pi     = v_pi[i];
      vif.vec_scan   = v_scan[i];
      vif.vec_exp_st = v_exp_st[i];
      vif.vec_exp_po = v_exp_po[i];
`ifdef XMASK_EN
      vif.vec_mask_st = v_mst[i];
      vif.vec_mask_po = v_mpo[i];
`endif
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (vif.vec_ready) begin ok = 1'b1; break; end
         if (done) break;
      end
      if (!ok && !done) chk("hs_timeout", 0, 1);
      if (ok) begin @(posedge clk); #1; end
      vif.vec_valid = 1'b0;
   endtask

   task automatic session_start(input bit stp);
      mon_clr = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      mon_clr = 1'b0;
      stop_on_fail = stp;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop_on_fail = 1'b0;
   endtask

   task automatic run_session(input int n, input bit stp, input int gap, input bit stk,
                              input int l_cnt, input int l_fails, input int l_first, input bit l_fail);
      bit ok;
      stuck1 = stk;
      n_vec  = n;
      build_model(n, stp, stk);
      session_start(stp);
      for (int i = 0; i < n; i++) begin
         feed_vec(i, ok);
         if (!ok) break;
         if (gap > 0 && i < n - 1) begin
            for (int t = 0; t < 100; t++) begin
               @(negedge clk);
               if (vif.vec_ready || done) break;
            end
            for (int g = 0; g < gap; g++) begin
               chk("gap_ready", vif.vec_ready, 1);
               chk("gap_nbart", NbarT, 0);
               @(negedge clk);
            end
            @(posedge clk); #1;
         end
      end
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("vec_count", vec_count, m_count);
      chk("fail_count", fail_count, m_fails);
      chk("first_fail", first_fail_idx, (m_first < 0) ? 32'hFFFF : m_first);
      chk("fail", fail, (m_fails != 0));
      chk("shift_runs", runs, m_runs);
      chk("lit_count", vec_count, l_cnt);
      chk("lit_fails", fail_count, l_fails);
      chk("lit_first", first_fail_idx, l_first);
      chk("lit_fail", fail, l_fail);
      stuck1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, vif.vec_ready, 0);
      chk({tag, "_nbart"}, NbarT, 0);
      chk({tag, "_si"}, si, 0);
      chk({tag, "_pi"}, dut_pi, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_vcnt"}, vec_count, 0);
      chk({tag, "_fcnt"}, fail_count, 0);
      chk({tag, "_ffi"}, first_fail_idx, 32'hFFFF);
   endtask

   task automatic reset_test();
      bit ok;
      int cnt;
      load_vecs(3, 1'b1);
      stuck1 = 1'b1;
      n_vec  = 3;
      build_model(3, 1'b0, 1'b1);
      session_start(1'b0);
      for (int i = 0; i < 3; i++) feed_vec(i, ok);
      cnt = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (NbarT) cnt++;
         if (cnt == 6) break;
      end
      chk("pre_rst_nbart", NbarT, 1);
      chk("pre_rst_fail", fail, 1);
      chk("pre_rst_vcnt", vec_count, 2);
      #1 global_reset = 1'b0;
      #1 chk_reset_vals("midrst");
      repeat (2) @(posedge clk);
      #1 global_reset = 1'b1;
      stuck1 = 1'b0;
   endtask

   initial begin
      global_reset   = 1'b0;
      start          = 1'b0;
      stop_on_fail   = 1'b0;
      mon_clr        = 1'b1;
      n_vec          = 0;
      vif.vec_valid  = 1'b0;
      vif.vec_last   = 1'b0;
      vif.vec_pi     = '0;
      vif.vec_scan   = '0;
      vif.vec_exp_st = '0;
      vif.vec_exp_po = '0;
`ifdef XMASK_EN
      vif.vec_mask_st = '0;
      vif.vec_mask_po = '0;
`endif
      fork
         monitor();
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk_reset_vals("rst");
            @(posedge clk); #1;
            global_reset = 1'b1;

            load_vecs(4, 1'b0);
            run_session(4, 1'b0, 0, 1'b0, 4, 0, 32'hFFFF, 1'b0);

            load_vecs(3, 1'b1);
            run_session(3, 1'b0, 0, 1'b1, 3, 3, 1, 1'b1);

            load_vecs(4, 1'b0);
            v_exp_po[0] = v_exp_po[0] ^ 8'h01;
            run_session(4, 1'b1, 0, 1'b0, 1, 1, 0, 1'b1);

            load_vecs(4, 1'b0);
            run_session(4, 1'b0, 5, 1'b0, 4, 0, 32'hFFFF, 1'b0);

            reset_test();
            load_vecs(4, 1'b0);
            run_session(4, 1'b0, 0, 1'b0, 4, 0, 32'hFFFF, 1'b0);
`ifdef XMASK_EN
            load_vecs(1, 1'b0);
            v_exp_po[0] = v_exp_po[0] ^ 8'h08;
            v_mpo[0]    = 8'h08;
            run_session(1, 1'b0, 0, 1'b0, 1, 0, 32'hFFFF, 1'b0);
            v_mpo[0]    = 8'h00;
            run_session(1, 1'b0, 0, 1'b0, 1, 1, 0, 1'b1);
`endif
         end
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
